// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the TX path (and the RX side later).
// UART_TX_PARITY_EN widens the state encoding to make room for the PARITY state.
package uart_pkg;

  localparam int unsigned UART_WIDTH        = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'h0,
    START  = 3'h1,
    DATA   = 3'h2,
    STOP   = 3'h3,
    PARITY = 3'h4
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'h0,
    START = 2'h1,
    DATA  = 2'h2,
    STOP  = 2'h3
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_end
// for the one cycle in which the next edge wraps the count.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  // bit_end is registered one count early so it lines up with the wrap edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else if (clear || !enable) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      bit_end <= (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/uart_tx_async.sv
// UART transmitter: start bit, WIDTH data bits LSB-first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_async
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = UART_WIDTH,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             ld_tx_data,
  input  logic             tx_en,
  output logic             tx_out,
  output logic             tx_busy
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic             tx_out_d, tx_busy_d;
  logic             capture_c;
  logic             bit_end;

  assign capture_c = (state_q == IDLE) && tx_en && ld_tx_data;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (capture_c),
    .enable  (state_q != IDLE),
    .bit_end (bit_end)
  );

  // State and datapath registers; outputs are flopped from the next-state view
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      tx_out    <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
      tx_out    <= tx_out_d;
      tx_busy   <= tx_busy_d;
    end
  end

  // Next state: capture in IDLE, advance one serial bit per bit_end
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (capture_c) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the upcoming state so the flops track the state register
  always_comb begin
    tx_out_d  = 1'b1;
    tx_busy_d = 1'b1;
    case (state_d)
      IDLE:    tx_busy_d = 1'b0;
      START:   tx_out_d  = 1'b0;
      DATA:    tx_out_d  = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_out_d  = parity_d;
`endif
      STOP:    tx_out_d  = 1'b1;
      default: tx_busy_d = 1'b0;
    endcase
  end

endmodule

// File: doc/uart_tx_async.md
Name: uart_tx_async

Overview:
Serial UART transmitter that sits directly downstream of the fifo read controller.
- Captures a parallel word on the ld_tx_data level strobe.
- Drives tx_busy back to the controller.
- Shifts the word out LSB-first as a start bit, WIDTH data bits and one stop bit, each bit lasting CLKS_PER_BIT clocks.
- tx_en lets a channel be switched off; the upstream 63-cycle timeout covers that case.

Parameters:
WIDTH, 8, data bits per frame (>=2)
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)

Ports:
clk  input  1  primary clock
reset_n  input  1  asynchronous digital reset (active low)
tx_data  input  WIDTH  parallel word to send; sampled only on the capture edge
ld_tx_data  input  1  high to transfer tx_data into the transmitter (level)
tx_en  input  1  high enables this transmitter; low blocks new captures
tx_out  output  1  serial line, idles high
tx_busy  output  1  high while a frame is in progress

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Registered outputs: all outputs come from flops, with no combinational path from inputs to outputs.
- Reset values: tx_out=1, tx_busy=0, state=IDLE. Shift register, baud counter and bit counter all clear.
- States:
  - IDLE: tx_out=1, tx_busy=0.
  - START: tx_out=0.
  - DATA: tx_out=shift[0].
  - STOP: tx_out=1.
  - tx_busy=1 in START, DATA and STOP.
- Capture edge C: a rising edge where state==IDLE and tx_en==1 and ld_tx_data==1.
  - At C: shift<=tx_data, state<=START, tx_busy<=1, tx_out<=0, baud counter<=0.
  - Latency from strobe to tx_busy is exactly one edge, which keeps the upstream timeout well clear.
- Bit timing:
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; the wrap marks the bit end.
  - At a bit end, state advances:
    - START->DATA.
    - Within DATA: shift right, bit counter++.
    - DATA->STOP after bit WIDTH-1.
    - STOP->IDLE.
- Frame length: tx_busy falls at edge C+(WIDTH+2)*CLKS_PER_BIT and tx_out stays 1. The earliest next capture is the following edge.
- Counter widths:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Bit counter width is $clog2(WIDTH).
  - No overflow occurs, because both counters wrap or clear at their terminal values.
- Boundary cases:
  - ld_tx_data high while tx_busy=1: ignored, and the in-flight frame is unaffected. This is the normal case, since the controller holds the strobe one cycle past tx_busy rising.
  - ld_tx_data high on the edge where STOP->IDLE: ignored, because the state is not yet IDLE.
  - tx_en low in IDLE: no capture, tx_busy stays 0, tx_out stays 1. The upstream controller times out.
  - tx_en dropped mid-frame: the frame completes normally. There is no truncation.
  - tx_data changing after C: no effect.
  - reset_n asserted mid-frame: tx_out goes to 1 and tx_busy to 0 immediately (asynchronously). The partial frame is abandoned.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx_out = even parity (XOR of the captured word), computed at C.
  - Frame length becomes (WIDTH+3)*CLKS_PER_BIT.
- Undefined: no parity state, no parity flop, and the frame length is (WIDTH+2)*CLKS_PER_BIT.

Decomposition:
- Package uart_pkg holds:
  - the tx state enum (IDLE=2'h0, START=2'h1, DATA=2'h2, STOP=2'h3);
  - a 3-bit encoding when parity is enabled;
  - default constants UART_WIDTH=8 and UART_CLKS_PER_BIT=16.
- One sub-module, uart_baud_gen:
  - Parameterised by CLKS_PER_BIT; has clear and enable inputs and outputs a one-cycle bit_end pulse.
  - Reused later by the RX side.

Test Plan (WIDTH=8, CLKS_PER_BIT=4):
1. Hold reset_n=0, then release with no stimulus -> tx_out=1, tx_busy=0 for 100 cycles.
2. tx_en=1, tx_data=0xA5, ld_tx_data pulsed 2 cycles -> tx_busy rises on the next edge and stays high 40 cycles. tx_out, 4 cycles per bit, is 0 | 1,0,1,0,0,1,0,1 | 1.
3. During test 2's frame, assert ld_tx_data with tx_data=0x3C at bit 3 -> waveform identical to test 2. No second frame follows unless re-strobed after tx_busy falls.
4. tx_en=0, ld_tx_data held high 64 cycles, tx_data=0xFF -> tx_busy never rises, tx_out constant 1. Raising tx_en then starts a frame one edge later.
5. Start a frame with 0x5A and assert reset_n=0 mid DATA bit 3 -> tx_out=1 and tx_busy=0 without waiting for a clock edge. After release, loading 0x00 gives 0 followed by eight 0s, then 1.
6. With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 is inserted before the stop bit, and tx_busy is high exactly 44 cycles.
